// File: rtl/hss_pkg.sv
// Shared definitions for the filterbank sequencer: FSM encoding and config-bus width.
package hss_pkg;

  localparam int unsigned CFG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2
  } fsm_state_e;

endpackage : hss_pkg

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream register slice; accepts a new beat in the same cycle the held one drains.
module axis_out_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned USER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic [USER_W-1:0] i_tuser,
  input  logic              i_tlast,
  input  logic              i_tready,
  output logic              o_tvalid,
  output logic [WIDTH-1:0]  o_tdata,
  output logic [USER_W-1:0] o_tuser,
  output logic              o_tlast,
  output logic              o_ready_c
);

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [USER_W-1:0] r_user;
  logic              r_last;

  // Payload only changes on a load, so it stays stable while valid waits for the sink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_tdata;
      r_user  <= i_tuser;
      r_last  <= i_tlast;
    end else if (i_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready_c = !r_valid || i_tready;
  assign o_tvalid  = r_valid;
  assign o_tdata   = r_data;
  assign o_tuser   = r_user;
  assign o_tlast   = r_last;

endmodule : axis_out_reg

// File: rtl/filterbank_sequencer.sv
// Time-multiplexes one FIR engine across NUM_FILTERS coefficient sets per input sample,
// tagging each result with its filter index and marking the last one.
module filterbank_sequencer
  import hss_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = 24,
  parameter int unsigned WIDTH       = 32
) (
  input  logic             aclk,
  input  logic             aresetn,

  input  logic [WIDTH-1:0] s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,

  output logic [WIDTH-1:0] m_axis_fir_data_tdata,
  output logic             m_axis_fir_data_tvalid,
  input  logic             m_axis_fir_data_tready,

  output logic [CFG_W-1:0] m_axis_fir_config_tdata,
  output logic             m_axis_fir_config_tvalid,
  input  logic             m_axis_fir_config_tready,

  input  logic [WIDTH-1:0] s_axis_fir_result_tdata,
  input  logic             s_axis_fir_result_tvalid,
  output logic             s_axis_fir_result_tready,

  output logic [WIDTH-1:0] m_axis_out_tdata,
  output logic             m_axis_out_tvalid,
  input  logic             m_axis_out_tready,
  output logic [CFG_W-1:0] m_axis_out_tuser,
  output logic             m_axis_out_tlast,

  output logic             busy
);

  localparam logic [CFG_W-1:0] LAST_IDX = CFG_W'(NUM_FILTERS - 1);

  fsm_state_e       r_state;
  fsm_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_sample;
  logic [CFG_W-1:0] r_idx;
  logic             r_data_vld;
  logic             r_cfg_vld;

  logic w_sample_hs;
  logic w_data_done;
  logic w_cfg_done;
  logic w_res_ready;
  logic w_res_hs;
  logic w_is_last;
  logic w_enter_issue;
  logic w_out_ready_c;

  assign w_sample_hs   = (r_state == ST_IDLE) && s_axis_data_tvalid;
  assign w_data_done   = !r_data_vld || m_axis_fir_data_tready;
  assign w_cfg_done    = !r_cfg_vld || m_axis_fir_config_tready;
  assign w_res_ready   = (r_state == ST_COLLECT) && w_out_ready_c;
  assign w_res_hs      = w_res_ready && s_axis_fir_result_tvalid;
  assign w_is_last     = (r_idx == LAST_IDX);
  assign w_enter_issue = (w_state_nxt == ST_ISSUE) && (r_state != ST_ISSUE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_sample_hs) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   if (w_data_done && w_cfg_done) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (w_res_hs) w_state_nxt = w_is_last ? ST_IDLE : ST_ISSUE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Sample/index latch and the two independent issue valids for the FIR engine.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sample   <= '0;
      r_idx      <= '0;
      r_data_vld <= 1'b0;
      r_cfg_vld  <= 1'b0;
    end else begin
      if (w_sample_hs) begin
        r_sample <= s_axis_data_tdata;
        r_idx    <= '0;
      end else if (w_res_hs && !w_is_last) begin
        r_idx <= r_idx + CFG_W'(1);
      end

      if (w_enter_issue) begin
        r_data_vld <= 1'b1;
        r_cfg_vld  <= 1'b1;
      end else begin
        if (m_axis_fir_data_tready)   r_data_vld <= 1'b0;
        if (m_axis_fir_config_tready) r_cfg_vld  <= 1'b0;
      end
    end
  end

  axis_out_reg #(
    .WIDTH  (WIDTH),
    .USER_W (CFG_W)
  ) u_out_reg (
    .clk       (aclk),
    .rst_n     (aresetn),
    .i_load    (w_res_hs),
    .i_tdata   (s_axis_fir_result_tdata),
    .i_tuser   (r_idx),
    .i_tlast   (w_is_last),
    .i_tready  (m_axis_out_tready),
    .o_tvalid  (m_axis_out_tvalid),
    .o_tdata   (m_axis_out_tdata),
    .o_tuser   (m_axis_out_tuser),
    .o_tlast   (m_axis_out_tlast),
    .o_ready_c (w_out_ready_c)
  );

  assign s_axis_data_tready       = (r_state == ST_IDLE);
  assign busy                     = (r_state != ST_IDLE);
  assign m_axis_fir_data_tdata    = r_sample;
  assign m_axis_fir_data_tvalid   = r_data_vld;
  assign m_axis_fir_config_tdata  = r_idx;
  assign m_axis_fir_config_tvalid = r_cfg_vld;
  assign s_axis_fir_result_tready = w_res_ready;

endmodule : filterbank_sequencer

// File: doc/filterbank_sequencer.md
FILTERBANK_SEQUENCER -- requirements
Module: filterbank_sequencer

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 24, number of coefficient sets applied per input sample (legal range 1..255).
REQ-002 SHALL have parameter WIDTH, default 32, signed sample/result width.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s_axis_data_tdata/tvalid/tready, in/in/out, WIDTH/1/1, incoming normalized sample stream.
REQ-006 SHALL have ports m_axis_fir_data_tdata/tvalid/tready, out/out/in, WIDTH/1/1, sample issued to the shared FIR engine.
REQ-007 SHALL have ports m_axis_fir_config_tdata/tvalid/tready, out/out/in, 8/1/1, FIR coefficient-set select; tdata = {zero-extend, filter index}.
REQ-008 SHALL have ports s_axis_fir_result_tdata/tvalid/tready, in/in/out, WIDTH/1/1, FIR engine result.
REQ-009 SHALL have ports m_axis_out_tdata/tvalid/tready/tuser/tlast, out/out/in/out/out, WIDTH/1/1/8/1, filtered output; tuser = filter index, tlast = last filter of a sample.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM with states IDLE, ISSUE, COLLECT.
REQ-012 IDLE: s_axis_data_tready=1; on tvalid&tready, latch sample, set idx=0, go to ISSUE next cycle.
REQ-013 In all other states, s_axis_data_tready SHALL be 0.
REQ-014 ISSUE: fir_data_tvalid and fir_config_tvalid SHALL be asserted together on entry; each deasserts independently on its own handshake; tdata stable while tvalid high.
REQ-015 ISSUE SHALL move to COLLECT the cycle after both handshakes have completed, including same-cycle completion.
REQ-016 COLLECT: s_axis_fir_result_tready = !out_valid | m_axis_out_tready (single-entry output register with pass-through refill).
REQ-017 On result handshake, SHALL load output register with tdata, tuser=idx, tlast=(idx==NUM_FILTERS-1), set out_valid.
REQ-018 After result handshake: if idx==NUM_FILTERS-1 go IDLE, else idx+1 and go ISSUE.
REQ-019 Output register SHALL hold until m_axis_out handshake; out_valid clears unless refilled same cycle.
REQ-020 Results arriving in IDLE or ISSUE SHALL NOT be accepted (result tready=0).
REQ-021 Minimum latency: sample accept to first m_axis_out_tvalid = 2 cycles + FIR latency; throughput bounded by one FIR round-trip per filter.
REQ-022 NUM_FILTERS=1: every output SHALL have tlast=1, tuser=0.
REQ-023 Sample data SHALL pass unmodified; no arithmetic on tdata.

Reset
REQ-024 Asserting aresetn low SHALL asynchronously force state IDLE, idx=0, all tvalid=0, tlast=0, tuser=0, tdata=0, busy=0.
REQ-025 Reset mid-sequence SHALL discard the latched sample and any pending output; first post-reset sample restarts at idx 0.
REQ-026 After deassertion, s_axis_data_tready SHALL be 1 on the first clock edge.

Structure
REQ-027 FSM state encoding and config-tdata width (8) SHALL live in shared package hss_pkg.
REQ-028 Output register SHALL be a sub-module axis_out_reg (single-entry register slice).
REQ-029 No other sub-modules; target 150-300 lines RTL.

Verification
REQ-030 NUM_FILTERS=3, sample 0x00400000, FIR model returns sample+idx after 4 cycles -> outputs 0x00400000/01/02, tuser 0,1,2, tlast only on third.
REQ-031 Config tready held low 5 cycles, data tready high -> data handshake once, config once after 5 cycles, no duplicate issue, COLLECT entered next cycle.
REQ-032 m_axis_out_tready low 10 cycles during result arrival -> result tready low after first capture, no result lost or overwritten.
REQ-033 aresetn low during COLLECT of idx 1 -> all valids 0 immediately, next sample starts with config tdata 0.
REQ-034 Back-to-back samples with tvalid always high -> second accepted only after tlast result captured; busy low exactly one cycle between.
REQ-035 Spurious result tvalid in IDLE -> result tready 0, no output produced.
